axis_frame_monitor: RTL and testbench

Single-channel AXI-Stream video monitor that taps a stream without driving it. It measures frame rate and backpressure over a programmable window, plus the beats-per-line and lines-per-frame of the last completed line and frame. It flags malformed framing with sticky error bits. It is the parametrised successor of axis_monitor: it adds TREADY-qualified transfers, configurable widths and window, saturating counters, and error detection. It sits on video pipeline taps and feeds status registers.

---
 rtl/axis_mon_pkg.sv | 20 ++
 rtl/window_timer.sv | 28 ++
 rtl/axis_frame_monitor.sv | 182 ++++++++++++++++++
 tb/tb_axis_frame_monitor.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_mon_pkg.sv
// Shared types and helpers for the AXI-Stream tap monitors.
// Holds the framing FSM state and the saturating counter step.
package axis_mon_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Callers truncate the result to the counter's own width.
    function automatic logic [63:0] sat_inc(
        input logic [63:0] value,
        input int unsigned width
    );
        logic [63:0] lim;
        lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= lim) ? lim : value + 64'd1;
    endfunction

endpackage

// File: rtl/window_timer.sv
// Free-running measurement window; term is high on the last cycle
// of every WINDOW_CYCLES-long window.
module window_timer #(
    parameter int unsigned WINDOW_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic term
);

    localparam int unsigned W = $clog2(WINDOW_CYCLES);
    localparam logic [W-1:0] LAST = W'(WINDOW_CYCLES - 1);

    logic [W-1:0] wcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else if (wcnt == LAST) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + 1'b1;
        end
    end

    assign term = (wcnt == LAST);

endmodule

// File: rtl/axis_frame_monitor.sv
// Passive AXI-Stream video tap: windowed frame rate and stall count,
// last line/frame geometry and sticky framing error flags.
module axis_frame_monitor
    import axis_mon_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 100_000_000,
    parameter int unsigned FWID          = 8,
    parameter int unsigned LWID          = 12,
    parameter int unsigned CWID          = 32
) (
    input  logic            ACLK,
    input  logic            RST,
    input  logic            AXIS_TVALID,
    input  logic            AXIS_TREADY,
    input  logic            AXIS_TUSER,
    input  logic            AXIS_TLAST,
    input  logic            CLR_ERR,
    output logic [FWID-1:0] FRAME_RATE,
    output logic [CWID-1:0] STALL_CNT,
    output logic [LWID-1:0] LINE_BEATS,
    output logic [LWID-1:0] FRAME_LINES,
    output logic            WIN_PULSE,
    output logic            ERR_LINE_LEN,
    output logic            ERR_SOF_MID
);

    logic xfer;
    logic sof;
    logic eol;
    logic stall;
    logic term;

    assign xfer  = AXIS_TVALID && AXIS_TREADY;
    assign sof   = xfer && AXIS_TUSER;
    assign eol   = xfer && AXIS_TLAST;
    assign stall = AXIS_TVALID && !AXIS_TREADY;

    window_timer #(
        .WINDOW_CYCLES(WINDOW_CYCLES)
    ) u_timer (
        .clk (ACLK),
        .rst (RST),
        .term(term)
    );

    logic [FWID-1:0] fr_acc;
    logic [FWID-1:0] fr_nx;
    logic [CWID-1:0] st_acc;
    logic [CWID-1:0] st_nx;

    always_comb begin
        fr_nx = fr_acc;
        st_nx = st_acc;
        if (sof) begin
            fr_nx = FWID'(sat_inc(64'(fr_acc), FWID));
        end
        if (stall) begin
            st_nx = CWID'(sat_inc(64'(st_acc), CWID));
        end
    end

    // Terminal-cycle events go into the published value, not the next window.
    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            fr_acc     <= '0;
            st_acc     <= '0;
            FRAME_RATE <= '0;
            STALL_CNT  <= '0;
            WIN_PULSE  <= 1'b0;
        end else begin
            WIN_PULSE <= term;
            if (term) begin
                FRAME_RATE <= fr_nx;
                STALL_CNT  <= st_nx;
                fr_acc     <= '0;
                st_acc     <= '0;
            end else begin
                fr_acc <= fr_nx;
                st_acc <= st_nx;
            end
        end
    end

    state_e          state;
    state_e          state_nx;
    logic [LWID-1:0] bc;
    logic [LWID-1:0] bc_nx;
    logic [LWID-1:0] lc;
    logic [LWID-1:0] lc_nx;
    logic [LWID-1:0] prev_len;
    logic [LWID-1:0] prev_nx;
    logic            pv;
    logic            pv_nx;
    logic [LWID-1:0] lb_nx;
    logic [LWID-1:0] fl_nx;
    logic [LWID-1:0] n;
    logic            act;
    logic            el_ev;
    logic            em_ev;
    logic            el_nx;
    logic            em_nx;

    always_comb begin
        state_nx = state;
        bc_nx    = bc;
        lc_nx    = lc;
        prev_nx  = prev_len;
        pv_nx    = pv;
        lb_nx    = LINE_BEATS;
        fl_nx    = FRAME_LINES;
        el_ev    = 1'b0;
        em_ev    = 1'b0;
        n        = LWID'(sat_inc(64'(bc), LWID));
        // The SOF that leaves SEARCH is already handled as an ACTIVE beat.
        act      = xfer && (state == ACTIVE || sof);
        if (sof) begin
            state_nx = ACTIVE;
        end
        if (act) begin
            unique case (1'b1)
                sof && eol: begin
                    em_ev   = (bc != '0);
                    if (lc != '0) begin
                        fl_nx = lc;
                    end
                    lb_nx   = LWID'(1);
                    lc_nx   = LWID'(1);
                    bc_nx   = '0;
                    prev_nx = LWID'(1);
                    pv_nx   = 1'b1;
                end
                sof && !eol: begin
                    em_ev = (bc != '0);
                    if (lc != '0) begin
                        fl_nx = lc;
                    end
                    lc_nx = '0;
                    pv_nx = 1'b0;
                    bc_nx = LWID'(1);
                end
                !sof && eol: begin
                    lb_nx   = n;
                    bc_nx   = '0;
                    lc_nx   = LWID'(sat_inc(64'(lc), LWID));
                    el_ev   = pv && (n != prev_len);
                    prev_nx = n;
                    pv_nx   = 1'b1;
                end
                default: begin
                    bc_nx = n;
                end
            endcase
        end
        el_nx = el_ev || (ERR_LINE_LEN && !CLR_ERR);
        em_nx = em_ev || (ERR_SOF_MID && !CLR_ERR);
    end

    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            state        <= SEARCH;
            bc           <= '0;
            lc           <= '0;
            prev_len     <= '0;
            pv           <= 1'b0;
            LINE_BEATS   <= '0;
            FRAME_LINES  <= '0;
            ERR_LINE_LEN <= 1'b0;
            ERR_SOF_MID  <= 1'b0;
        end else begin
            state        <= state_nx;
            bc           <= bc_nx;
            lc           <= lc_nx;
            prev_len     <= prev_nx;
            pv           <= pv_nx;
            LINE_BEATS   <= lb_nx;
            FRAME_LINES  <= fl_nx;
            ERR_LINE_LEN <= el_nx;
            ERR_SOF_MID  <= em_nx;
        end
    end

endmodule

// File: tb/tb_axis_frame_monitor.sv
// Randomized bench for axis_frame_monitor against a frame-level model.
module tb_axis_frame_monitor;

    localparam int WIN = 1000;
    localparam int FW  = 8;
    localparam int LW  = 12;
    localparam int CW  = 32;

    logic          ACLK = 1'b0;
    logic          RST;
    logic          AXIS_TVALID;
    logic          AXIS_TREADY;
    logic          AXIS_TUSER;
    logic          AXIS_TLAST;
    logic          CLR_ERR;
    logic [FW-1:0] FRAME_RATE;
    logic [CW-1:0] STALL_CNT;
    logic [LW-1:0] LINE_BEATS;
    logic [LW-1:0] FRAME_LINES;
    logic          WIN_PULSE;
    logic          ERR_LINE_LEN;
    logic          ERR_SOF_MID;

    axis_frame_monitor #(
        .WINDOW_CYCLES(WIN),
        .FWID(FW),
        .LWID(LW),
        .CWID(CW)
    ) dut (
        .ACLK(ACLK),
        .RST(RST),
        .AXIS_TVALID(AXIS_TVALID),
        .AXIS_TREADY(AXIS_TREADY),
        .AXIS_TUSER(AXIS_TUSER),
        .AXIS_TLAST(AXIS_TLAST),
        .CLR_ERR(CLR_ERR),
        .FRAME_RATE(FRAME_RATE),
        .STALL_CNT(STALL_CNT),
        .LINE_BEATS(LINE_BEATS),
        .FRAME_LINES(FRAME_LINES),
        .WIN_PULSE(WIN_PULSE),
        .ERR_LINE_LEN(ERR_LINE_LEN),
        .ERR_SOF_MID(ERR_SOF_MID)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state: window position, accumulators, line/frame tallies.
    int     m_cyc;
    longint m_fr_acc, m_st_acc;
    bit     m_in_frame;
    longint m_beats, m_lines, m_prev;
    longint exp_fr, exp_st, exp_lb, exp_fl;
    bit     exp_pulse, exp_el, exp_em;

    function automatic longint sat(longint v, int w);
        longint lim = (longint'(1) << w) - 1;
        return (v >= lim) ? lim : v + 1;
    endfunction

    function automatic void model_reset();
        m_cyc = 0; m_fr_acc = 0; m_st_acc = 0;
        m_in_frame = 0; m_beats = 0; m_lines = 0; m_prev = -1;
        exp_fr = 0; exp_st = 0; exp_lb = 0; exp_fl = 0;
        exp_pulse = 0; exp_el = 0; exp_em = 0;
    endfunction

    function automatic void model_step(bit v, bit r, bit u, bit l, bit c);
        bit x = v && r;
        bit sof = x && u;
        bit eol = x && l;
        bit stl = v && !r;
        bit el_ev = 0;
        bit em_ev = 0;
        longint fa = sof ? sat(m_fr_acc, FW) : m_fr_acc;
        longint sa = stl ? sat(m_st_acc, CW) : m_st_acc;
        exp_pulse = (m_cyc == WIN - 1);
        if (exp_pulse) begin
            exp_fr = fa; exp_st = sa;
            m_fr_acc = 0; m_st_acc = 0; m_cyc = 0;
        end else begin
            m_fr_acc = fa; m_st_acc = sa; m_cyc++;
        end
        if (x && (m_in_frame || sof)) begin
            m_in_frame = 1;
            if (sof) begin
                if (m_beats != 0) em_ev = 1;
                if (m_lines != 0) exp_fl = m_lines;
                m_lines = 0; m_prev = -1; m_beats = 0;
            end
            m_beats = sat(m_beats, LW);
            if (eol) begin
                exp_lb = m_beats;
                if (m_prev >= 0 && m_beats != m_prev) el_ev = 1;
                m_prev = m_beats;
                m_lines = sat(m_lines, LW);
                m_beats = 0;
            end
        end
        exp_el = el_ev ? 1'b1 : (c ? 1'b0 : exp_el);
        exp_em = em_ev ? 1'b1 : (c ? 1'b0 : exp_em);
    endfunction

    task automatic drive(input bit v, input bit r, input bit u, input bit l, input bit c);
        AXIS_TVALID = v; AXIS_TREADY = r;
        AXIS_TUSER = u; AXIS_TLAST = l; CLR_ERR = c;
        model_step(v, r, u, l, c);
        @(posedge ACLK);
        cyc++;
        @(negedge ACLK);
    endtask

    // One transfer, preceded by a random run of non-transfer cycles.
    task automatic beat(input bit u, input bit l, input bit c);
        while ($urandom_range(3) == 0)
            drive(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
        drive(1'b1, 1'b1, u, l, c);
    endtask

    task automatic send_line(input int len, input bit sof_first);
        for (int b = 0; b < len; b++)
            beat(sof_first && b == 0, b == len - 1, 1'b0);
    endtask

    task automatic do_reset();
        AXIS_TVALID = 0; AXIS_TREADY = 0; AXIS_TUSER = 0; AXIS_TLAST = 0; CLR_ERR = 0;
        RST = 1'b1;
        model_reset();
        @(posedge ACLK);
        @(negedge ACLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        AXIS_TVALID = 1; AXIS_TREADY = 1; AXIS_TUSER = 1; AXIS_TLAST = 1; CLR_ERR = 0;
        RST = 1'b1;
        #1;
        n_cmp++;
        if ({FRAME_RATE, STALL_CNT, LINE_BEATS, FRAME_LINES, WIN_PULSE, ERR_LINE_LEN, ERR_SOF_MID} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got fr=%0d st=%0d lb=%0d fl=%0d p=%0b el=%0b em=%0b expected all 0",
                     FRAME_RATE, STALL_CNT, LINE_BEATS, FRAME_LINES, WIN_PULSE, ERR_LINE_LEN, ERR_SOF_MID);
        end
        @(negedge ACLK);
        do_reset();
    endtask

    task automatic test_frame_rate();
        int k = $urandom_range(0, 199);
        int pulses = 0;
        int last = 0;
        int guard = 0;
        while (pulses < 2 && guard < 2600) begin
            if ((m_cyc % 200) == k) drive(1, 1, 1, 1, 0);
            else drive(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
            guard++;
            n_cmp++;
            if (WIN_PULSE !== exp_pulse) begin
                n_bad++;
                $display("FAIL win_pulse: got %0b expected %0b at cycle %0d", WIN_PULSE, exp_pulse, cyc);
            end
            if (exp_pulse) begin
                pulses++;
                n_cmp++;
                if (FRAME_RATE !== exp_fr[FW-1:0]) begin
                    n_bad++;
                    $display("FAIL frame_rate: got %0d expected %0d", FRAME_RATE, exp_fr);
                end
                n_cmp++;
                if (STALL_CNT !== exp_st[CW-1:0]) begin
                    n_bad++;
                    $display("FAIL stall_zero: got %0d expected %0d", STALL_CNT, exp_st);
                end
                if (pulses == 2) begin
                    n_cmp++;
                    if (cyc - last != WIN) begin
                        n_bad++;
                        $display("FAIL pulse_period: got %0d expected %0d", cyc - last, WIN);
                    end
                end
                last = cyc;
            end
        end
        if (pulses < 2) begin
            n_cmp++; n_bad++;
            $display("FAIL frame_rate_timeout: got %0d pulses expected 2", pulses);
        end
    endtask

    task automatic test_stall();
        int st = $urandom_range(10, 500);
        int guard = 0;
        bit seen = 0;
        while (!seen && guard < 1100) begin
            if (guard >= st && guard < st + 37)
                drive(1, 0, 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
            else
                drive(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
            guard++;
            seen = exp_pulse;
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL stall_timeout: got no window end expected one");
        end else begin
            n_cmp++;
            if (STALL_CNT !== exp_st[CW-1:0]) begin
                n_bad++;
                $display("FAIL stall_cnt: got %0d expected %0d", STALL_CNT, exp_st);
            end
            n_cmp++;
            if (FRAME_RATE !== exp_fr[FW-1:0]) begin
                n_bad++;
                $display("FAIL stall_frame_rate: got %0d expected %0d", FRAME_RATE, exp_fr);
            end
        end
    endtask

    task automatic test_lines();
        do_reset();
        for (int ln = 0; ln < 4; ln++) begin
            send_line(16, ln == 0);
            n_cmp++;
            if (LINE_BEATS !== exp_lb[LW-1:0]) begin
                n_bad++;
                $display("FAIL line_beats: got %0d expected %0d", LINE_BEATS, exp_lb);
            end
        end
        beat(1, 0, 0);
        n_cmp++;
        if (FRAME_LINES !== exp_fl[LW-1:0]) begin
            n_bad++;
            $display("FAIL frame_lines: got %0d expected %0d", FRAME_LINES, exp_fl);
        end
        n_cmp++;
        if ({ERR_LINE_LEN, ERR_SOF_MID} !== {exp_el, exp_em}) begin
            n_bad++;
            $display("FAIL lines_no_err: got %0b%0b expected %0b%0b", ERR_LINE_LEN, ERR_SOF_MID, exp_el, exp_em);
        end
    endtask

    task automatic test_len_err();
        do_reset();
        send_line(16, 1);
        send_line(16, 0);
        send_line(15, 0);
        n_cmp++;
        if (ERR_LINE_LEN !== exp_el) begin
            n_bad++;
            $display("FAIL len_err_set: got %0b expected %0b", ERR_LINE_LEN, exp_el);
        end
        repeat (5) drive(0, 0, 0, 0, 0);
        n_cmp++;
        if (ERR_LINE_LEN !== exp_el) begin
            n_bad++;
            $display("FAIL len_err_sticky: got %0b expected %0b", ERR_LINE_LEN, exp_el);
        end
        drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (ERR_LINE_LEN !== exp_el) begin
            n_bad++;
            $display("FAIL len_err_clear: got %0b expected %0b", ERR_LINE_LEN, exp_el);
        end
        send_line(9, 1);
        send_line(9, 0);
        n_cmp++;
        if ({ERR_LINE_LEN, ERR_SOF_MID, LINE_BEATS} !== {exp_el, exp_em, exp_lb[LW-1:0]}) begin
            n_bad++;
            $display("FAIL new_frame_no_cmp: got %0b%0b lb=%0d expected %0b%0b lb=%0d",
                     ERR_LINE_LEN, ERR_SOF_MID, LINE_BEATS, exp_el, exp_em, exp_lb);
        end
    endtask

    task automatic test_sof_mid();
        repeat (3) beat(0, 0, 0);
        beat(1, 0, 1);
        n_cmp++;
        if (ERR_SOF_MID !== exp_em) begin
            n_bad++;
            $display("FAIL sof_mid_wins_clr: got %0b expected %0b", ERR_SOF_MID, exp_em);
        end
        drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (ERR_SOF_MID !== exp_em) begin
            n_bad++;
            $display("FAIL sof_mid_clear: got %0b expected %0b", ERR_SOF_MID, exp_em);
        end
    endtask

    task automatic test_search_tlast();
        do_reset();
        repeat (4) beat(0, 1, 0);
        n_cmp++;
        if ({LINE_BEATS, FRAME_LINES} !== {exp_lb[LW-1:0], exp_fl[LW-1:0]}) begin
            n_bad++;
            $display("FAIL search_tlast: got lb=%0d fl=%0d expected lb=%0d fl=%0d",
                     LINE_BEATS, FRAME_LINES, exp_lb, exp_fl);
        end
        send_line(5, 1);
        send_line(5, 0);
        beat(1, 0, 0);
        beat(0, 0, 0);
        #2;
        RST = 1'b1;
        #1;
        n_cmp++;
        if ({FRAME_RATE, STALL_CNT, LINE_BEATS, FRAME_LINES, WIN_PULSE, ERR_LINE_LEN, ERR_SOF_MID} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got lb=%0d fl=%0d fr=%0d expected all 0", LINE_BEATS, FRAME_LINES, FRAME_RATE);
        end
        @(negedge ACLK);
        do_reset();
        repeat (3) beat(0, 1, 0);
        n_cmp++;
        if (LINE_BEATS !== exp_lb[LW-1:0]) begin
            n_bad++;
            $display("FAIL search_after_rst: got %0d expected %0d", LINE_BEATS, exp_lb);
        end
        send_line(7, 1);
        n_cmp++;
        if (LINE_BEATS !== exp_lb[LW-1:0]) begin
            n_bad++;
            $display("FAIL active_after_rst: got %0d expected %0d", LINE_BEATS, exp_lb);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(39) == 0,
                  $urandom_range(7) == 0, $urandom_range(49) == 0);
            n_cmp++;
            if (FRAME_RATE !== exp_fr[FW-1:0]) begin
                n_bad++; $display("FAIL rnd_fr: got %0d expected %0d @%0d", FRAME_RATE, exp_fr, i);
            end
            n_cmp++;
            if (STALL_CNT !== exp_st[CW-1:0]) begin
                n_bad++; $display("FAIL rnd_st: got %0d expected %0d @%0d", STALL_CNT, exp_st, i);
            end
            n_cmp++;
            if (LINE_BEATS !== exp_lb[LW-1:0]) begin
                n_bad++; $display("FAIL rnd_lb: got %0d expected %0d @%0d", LINE_BEATS, exp_lb, i);
            end
            n_cmp++;
            if (FRAME_LINES !== exp_fl[LW-1:0]) begin
                n_bad++; $display("FAIL rnd_fl: got %0d expected %0d @%0d", FRAME_LINES, exp_fl, i);
            end
            n_cmp++;
            if (WIN_PULSE !== exp_pulse) begin
                n_bad++; $display("FAIL rnd_pulse: got %0b expected %0b @%0d", WIN_PULSE, exp_pulse, i);
            end
            n_cmp++;
            if (ERR_LINE_LEN !== exp_el) begin
                n_bad++; $display("FAIL rnd_el: got %0b expected %0b @%0d", ERR_LINE_LEN, exp_el, i);
            end
            n_cmp++;
            if (ERR_SOF_MID !== exp_em) begin
                n_bad++; $display("FAIL rnd_em: got %0b expected %0b @%0d", ERR_SOF_MID, exp_em, i);
            end
        end
    endtask

    initial begin
        RST = 1'b0;
        AXIS_TVALID = 0; AXIS_TREADY = 0; AXIS_TUSER = 0; AXIS_TLAST = 0; CLR_ERR = 0;
        model_reset();
        @(negedge ACLK);
        test_reset();
        test_frame_rate();
        test_stall();
        test_lines();
        test_len_err();
        test_sof_mid();
        test_search_tlast();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
